alu_acc: RTL

ALU_ACC -- requirements
Module: alu_acc

---
 rtl/alu_acc.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_acc.sv
// Accumulator ALU with single-cycle ops and an optional 16-cycle shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 111 is a NOP and busy is tied low.
module alu_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus,
    input  logic [2:0]  alu_op,
    input  logic        start,
    output logic [15:0] ac,
    output logic        z_flag,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {
        OP_NOP = 3'b000, OP_CLR = 3'b001, OP_LOAD = 3'b010, OP_ADD = 3'b011,
        OP_SUB = 3'b100, OP_INC = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
    } op_e;

    logic [15:0] ac_q, ac_d;
    logic        z_q, z_d;
    logic        done_q, done_d;
    logic        ac_we;
    logic        accept;
    op_e         op;

    assign op = op_e'(alu_op);

`ifdef ALU_MUL_EN
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] prod_nx;

    assign accept  = start && !busy_q;
    assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);
    assign busy    = busy_q;
`else
    assign accept  = start;
    assign busy    = 1'b0;
`endif

    always_comb begin
        ac_d   = ac_q;
        ac_we  = 1'b0;
        done_d = 1'b0;
`ifdef ALU_MUL_EN
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
`endif
        if (accept) begin
            done_d = 1'b1;
            case (op)
                OP_CLR:  begin ac_d = 16'h0000;     ac_we = 1'b1; end
                OP_LOAD: begin ac_d = bus;          ac_we = 1'b1; end
                OP_ADD:  begin ac_d = ac_q + bus;   ac_we = 1'b1; end
                OP_SUB:  begin ac_d = ac_q - bus;   ac_we = 1'b1; end
                OP_INC:  begin ac_d = ac_q + 16'd1; ac_we = 1'b1; end
                OP_SHR:  begin ac_d = {1'b0, ac_q[15:1]}; ac_we = 1'b1; end
`ifdef ALU_MUL_EN
                OP_MUL: begin
                    // Operands are latched here so the bus may float during the iterations.
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = 4'd0;
                    mcand_d  = ac_q;
                    mplier_d = bus;
                    prod_d   = 16'h0000;
                end
`endif
                default: ;
            endcase
        end
`ifdef ALU_MUL_EN
        else if (busy_q) begin
            prod_d   = prod_nx;
            mcand_d  = {mcand_q[14:0], 1'b0};
            mplier_d = {1'b0, mplier_q[15:1]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                ac_d   = prod_nx;
                ac_we  = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
`endif
        z_d = ac_we ? (ac_d == 16'h0000) : z_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q     <= 16'h0000;
            z_q      <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q   <= 1'b0;
            cnt_q    <= 4'd0;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            prod_q   <= 16'h0000;
`endif
        end else begin
            ac_q     <= ac_d;
            z_q      <= z_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
`endif
        end
    end

    assign ac     = ac_q;
    assign z_flag = z_q;
    assign done   = done_q;
endmodule
